// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two valid/ready requesters.
// Optional opcode screening at acceptance is enabled by defining ALU_ARB_OPCHECK_EN.

module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_data1,
  input  logic [DATA_WIDTH-1:0] req0_data2,
  input  logic [OP_WIDTH-1:0]   req0_op,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_result,
  output logic                  rsp0_err,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_data1,
  input  logic [DATA_WIDTH-1:0] req1_data2,
  input  logic [OP_WIDTH-1:0]   req1_op,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_result,
  output logic                  rsp1_err,

  output logic [DATA_WIDTH-1:0] alu_data1,
  output logic [DATA_WIDTH-1:0] alu_data2,
  output logic [OP_WIDTH-1:0]   alu_operation,
  input  logic [DATA_WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  last_grant_r;
  logic                  owner_r;
  logic                  grant_valid_s;
  logic                  grant_id_s;
  logic                  accept_s;
  logic                  accept_legal_s;
  logic                  reject_s;
  logic                  rsp_take_s;
  logic                  req0_ready_s;
  logic                  req1_ready_s;
  logic [DATA_WIDTH-1:0] sel_data1_s;
  logic [DATA_WIDTH-1:0] sel_data2_s;
  logic [OP_WIDTH-1:0]   sel_op_s;
  logic [DATA_WIDTH-1:0] alu_data1_r;
  logic [DATA_WIDTH-1:0] alu_data2_r;
  logic [OP_WIDTH-1:0]   alu_operation_r;
  logic                  rsp0_valid_r;
  logic                  rsp1_valid_r;
  logic [DATA_WIDTH-1:0] rsp0_result_r;
  logic [DATA_WIDTH-1:0] rsp1_result_r;
  logic                  rsp0_err_r;
  logic                  rsp1_err_r;

`ifdef ALU_ARB_OPCHECK_EN
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(4'b0000);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(4'b0001);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(4'b0010);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(4'b0110);
  localparam logic [OP_WIDTH-1:0] OP_SLT = OP_WIDTH'(4'b0111);

  function automatic logic opcode_legal(input logic [OP_WIDTH-1:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
      default:                              legal = 1'b0;
    endcase
    return legal;
  endfunction

  assign accept_legal_s = opcode_legal(sel_op_s);
`else
  assign accept_legal_s = 1'b1;
`endif

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = ~last_grant_r;
    end else if (req0_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b0;
    end else if (req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_data1_s = req0_data1;
    sel_data2_s = req0_data2;
    sel_op_s    = req0_op;
    if (grant_id_s) begin
      sel_data1_s = req1_data1;
      sel_data2_s = req1_data2;
      sel_op_s    = req1_op;
    end else begin
      sel_data1_s = req0_data1;
      sel_data2_s = req0_data2;
      sel_op_s    = req0_op;
    end
  end

  assign accept_s = !rst && (state_r == IDLE) && grant_valid_s;
  assign reject_s = accept_s && !accept_legal_s;

  // Response handshake of the current owner.
  always_comb begin
    rsp_take_s = 1'b0;
    if (state_r == RESP) begin
      rsp_take_s = owner_r ? (rsp1_valid_r && rsp1_ready) : (rsp0_valid_r && rsp0_ready);
    end else begin
      rsp_take_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; rejected opcodes bypass EXEC.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = accept_legal_s ? EXEC : RESP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (rsp_take_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: request ready only while idle.
  always_comb begin
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    if (accept_s) begin
      req0_ready_s = ~grant_id_s;
      req1_ready_s = grant_id_s;
    end else begin
      req0_ready_s = 1'b0;
      req1_ready_s = 1'b0;
    end
  end

  // Arbitration history and ownership of the operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
    end else if (accept_s) begin
      last_grant_r <= grant_id_s;
      owner_r      <= grant_id_s;
    end
  end

  // ALU operand registers, loaded only for operations that will execute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_data1_r     <= {DATA_WIDTH{1'b0}};
      alu_data2_r     <= {DATA_WIDTH{1'b0}};
      alu_operation_r <= {OP_WIDTH{1'b0}};
    end else if (accept_s && accept_legal_s) begin
      alu_data1_r     <= sel_data1_s;
      alu_data2_r     <= sel_data2_s;
      alu_operation_r <= sel_op_s;
    end
  end

  // Response registers: capture in EXEC (or on rejection), release on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_r  <= 1'b0;
      rsp1_valid_r  <= 1'b0;
      rsp0_result_r <= {DATA_WIDTH{1'b0}};
      rsp1_result_r <= {DATA_WIDTH{1'b0}};
      rsp0_err_r    <= 1'b0;
      rsp1_err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (reject_s && grant_id_s) begin
            rsp1_valid_r  <= 1'b1;
            rsp1_result_r <= {DATA_WIDTH{1'b0}};
            rsp1_err_r    <= 1'b1;
          end else if (reject_s) begin
            rsp0_valid_r  <= 1'b1;
            rsp0_result_r <= {DATA_WIDTH{1'b0}};
            rsp0_err_r    <= 1'b1;
          end
        end
        EXEC: begin
          if (owner_r) begin
            rsp1_valid_r  <= 1'b1;
            rsp1_result_r <= alu_result;
            rsp1_err_r    <= 1'b0;
          end else begin
            rsp0_valid_r  <= 1'b1;
            rsp0_result_r <= alu_result;
            rsp0_err_r    <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_take_s && owner_r) begin
            rsp1_valid_r <= 1'b0;
          end else if (rsp_take_s) begin
            rsp0_valid_r <= 1'b0;
          end
        end
        default: begin
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready    = req0_ready_s;
  assign req1_ready    = req1_ready_s;
  assign rsp0_valid    = rsp0_valid_r;
  assign rsp1_valid    = rsp1_valid_r;
  assign rsp0_result   = rsp0_result_r;
  assign rsp1_result   = rsp1_result_r;
  assign rsp0_err      = rsp0_err_r;
  assign rsp1_err      = rsp1_err_r;
  assign alu_data1     = alu_data1_r;
  assign alu_data2     = alu_data2_r;
  assign alu_operation = alu_operation_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized self-checking bench for alu_share_arbiter against a transaction-level model.
// Honours ALU_ARB_OPCHECK_EN when the same macro is defined for the bench.

module tb_alu_share_arbiter;

`ifdef ALU_ARB_OPCHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data1 = 32'd0, req0_data2 = 32'd0, req1_data1 = 32'd0, req1_data2 = 32'd0;
  logic [3:0]  req0_op = 4'd0, req1_op = 4'd0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_err, rsp1_err;
  logic [31:0] alu_data1, alu_data2, alu_result;
  logic [3:0]  alu_operation;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data1(req0_data1),
    .req0_data2(req0_data2), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data1(req1_data1),
    .req1_data2(req1_data2), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_operation(alu_operation),
    .alu_result(alu_result)
  );

  // Behavioural ALU; unknown codes produce XOR so they are distinguishable from 0.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a ^ b;
    endcase
  endfunction

  function automatic bit op_legal(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd6) || (op == 4'd7);
  endfunction

  assign alu_result = alu_fn(alu_operation, alu_data1, alu_data2);

  int checks = 0;
  int errors = 0;

  // Pending requests and expected DUT-visible state.
  logic [1:0]  p_v;
  logic [31:0] p_a [2];
  logic [31:0] p_b [2];
  logic [3:0]  p_op [2];
  logic [1:0]  m_rdy, m_vld, m_err;
  logic [31:0] m_res [2];
  logic [31:0] m_a1, m_a2;
  logic [3:0]  m_op;
  int          m_last;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    #1;
    check_val("req0_ready", req0_ready, m_rdy[0]);
    check_val("req1_ready", req1_ready, m_rdy[1]);
    check_val("rsp0_valid", rsp0_valid, m_vld[0]);
    check_val("rsp1_valid", rsp1_valid, m_vld[1]);
    check_val("rsp0_result", rsp0_result, m_res[0]);
    check_val("rsp1_result", rsp1_result, m_res[1]);
    check_val("rsp0_err", rsp0_err, m_err[0]);
    check_val("rsp1_err", rsp1_err, m_err[1]);
    check_val("alu_data1", alu_data1, m_a1);
    check_val("alu_data2", alu_data2, m_a2);
    check_val("alu_operation", alu_operation, m_op);
  endtask

  task automatic model_reset();
    m_rdy = 2'b00; m_vld = 2'b00; m_err = 2'b00;
    m_res[0] = 32'd0; m_res[1] = 32'd0;
    m_a1 = 32'd0; m_a2 = 32'd0; m_op = 4'd0;
    m_last = 1;
  endtask

  function automatic int winner();
    if (p_v[0] && p_v[1]) return (m_last == 0) ? 1 : 0;
    if (p_v[0]) return 0;
    if (p_v[1]) return 1;
    return -1;
  endfunction

  task automatic idle_ready();
    int w;
    w = winner();
    m_rdy[0] = (w == 0);
    m_rdy[1] = (w == 1);
  endtask

  task automatic apply_reqs();
    req0_valid = p_v[0]; req0_data1 = p_a[0]; req0_data2 = p_b[0]; req0_op = p_op[0];
    req1_valid = p_v[1]; req1_data1 = p_a[1]; req1_data2 = p_b[1]; req1_op = p_op[1];
  endtask

  task automatic set_rsp_ready(input int n, input logic v);
    if (n == 0) rsp0_ready = v;
    else        rsp1_ready = v;
  endtask

  function automatic logic [3:0] rand_op();
    logic [3:0] legal_ops [5];
    legal_ops[0] = 4'd0; legal_ops[1] = 4'd1; legal_ops[2] = 4'd2;
    legal_ops[3] = 4'd6; legal_ops[4] = 4'd7;
    if ($urandom_range(0, 3) != 0) return legal_ops[$urandom_range(0, 4)];
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic set_req(input int n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    p_v[n] = 1'b1; p_op[n] = op; p_a[n] = a; p_b[n] = b;
  endtask

  // Serve one operation starting from an idle negedge; optionally raise the other requester mid-flight.
  task automatic serve_one(input int bp, input bit late);
    int w, o;
    bit lg;
    apply_reqs();
    w = winner();
    o = 1 - w;
    idle_ready();
    check_all();
    @(posedge clk);
    m_last = w;
    lg = OPCHK ? op_legal(p_op[w]) : 1'b1;
    @(negedge clk);
    p_v[w] = 1'b0;
    if (late && !p_v[o]) set_req(o, rand_op(), $urandom, $urandom);
    apply_reqs();
    m_rdy = 2'b00;
    if (lg) begin
      m_a1 = p_a[w]; m_a2 = p_b[w]; m_op = p_op[w];
      check_all();
      @(negedge clk);
      m_res[w] = alu_fn(p_op[w], p_a[w], p_b[w]);
      m_err[w] = 1'b0;
    end else begin
      m_res[w] = 32'd0;
      m_err[w] = 1'b1;
    end
    m_vld[w] = 1'b1;
    check_all();
    repeat (bp) begin
      set_rsp_ready(o, 1'($urandom_range(0, 1)));
      @(negedge clk);
      check_all();
    end
    set_rsp_ready(w, 1'b1);
    check_all();
    @(negedge clk);
    set_rsp_ready(w, 1'b0);
    set_rsp_ready(o, 1'b0);
    m_vld[w] = 1'b0;
    idle_ready();
    check_all();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    p_v = 2'b00;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    apply_reqs();
    model_reset();
    check_all();
    repeat (cycles) begin
      @(negedge clk);
      check_all();
    end
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    p_v = 2'b00;
    for (int i = 0; i < 2; i++) begin p_a[i] = 32'd0; p_b[i] = 32'd0; p_op[i] = 4'd0; end
    model_reset();
    @(negedge clk);
    do_reset(9);

    // First operation after reset: ADD 2+1.
    set_req(0, 4'b0010, 32'd2, 32'd1);
    serve_one(0, 1'b0);

    // Simultaneous pairs from a fresh reset: req0 first, then req1, twice.
    @(negedge clk);
    do_reset(2);
    set_req(0, 4'b0000, 32'd10, 32'd6);
    set_req(1, 4'b0001, 32'd10, 32'd5);
    serve_one(1, 1'b0);
    serve_one(0, 1'b0);
    set_req(0, 4'b0010, 32'd100, 32'd23);
    set_req(1, 4'b0110, 32'd50, 32'd8);
    serve_one(0, 1'b0);
    serve_one(0, 1'b0);

    // Backpressure on req1 while req0 waits.
    set_req(1, 4'b0110, 32'd2, 32'd2);
    serve_one(5, 1'b1);
    serve_one(0, 1'b0);

    // Signed compare.
    set_req(0, 4'b0111, 32'hFFFF_FFF6, 32'd5);
    serve_one(1, 1'b0);

    // Reset while the operation sits in EXEC.
    set_req(0, 4'b0010, 32'd3, 32'd4);
    apply_reqs();
    idle_ready();
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    p_v = 2'b00;
    apply_reqs();
    rst = 1'b0;
    check_all();
    @(negedge clk);
    check_all();
    set_req(1, 4'b0010, 32'd7, 32'd8);
    serve_one(0, 1'b0);

    // Undefined opcode: rejected early with the check, passed through without it.
    set_req(0, 4'b1111, 32'd5, 32'd3);
    serve_one(1, 1'b0);

    // Randomized traffic.
    for (int r = 0; r < 300; r++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        idle_ready();
        check_all();
      end
      case ($urandom_range(0, 2))
        0: set_req(0, rand_op(), $urandom, $urandom);
        1: set_req(1, rand_op(), $urandom, $urandom);
        default: begin
          set_req(0, rand_op(), $urandom, $urandom);
          set_req(1, rand_op(), $urandom, $urandom);
        end
      endcase
      while (p_v != 2'b00) begin
        serve_one($urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational pipeline ALU between two requesters, e.g. the EX stage and a multi-cycle helper unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. Operands are registered, the ALU result is captured and held until the owning requester takes it.
- Sits between the requesters and the ALU's data1/data2/operation/alu_result pins.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OP_WIDTH, 4, ALU operation code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  arbiter accepts requester 0 this cycle.
- req0_data1  in  DATA_WIDTH  operand 1.
- req0_data2  in  DATA_WIDTH  operand 2.
- req0_op  in  OP_WIDTH  ALU operation code.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 takes result.
- rsp0_result  out  DATA_WIDTH  result.
- rsp0_err  out  1  opcode rejected (see Optional Feature).
- req1_*, rsp1_*  same set as requester 0, for requester 1.
- alu_data1  out  DATA_WIDTH  to ALU data1.
- alu_data2  out  DATA_WIDTH  to ALU data2.
- alu_operation  out  OP_WIDTH  to ALU operation.
- alu_result  in  DATA_WIDTH  from ALU (combinational).

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: all outputs 0, alu_operation 4'b0000, last_grant=1 (requester 0 wins first).
- IDLE, grant selection:
  - Exactly one reqN_valid high: grant N.
  - Both high: grant the requester that is not last_grant.
  - Neither high: no grant.
- IDLE, ready: reqN_ready = granted N (combinational from the valids). At most one ready high per cycle; both ready are low outside IDLE.
- Transfer on reqN_valid & reqN_ready:
  - Register data1/data2/op onto alu_* and record owner=N.
  - Set last_grant=N.
  - Go to EXEC.
- EXEC (one cycle): alu_* stable. At the clock edge, capture alu_result into rspN_result and set rspN_valid for the owner. Go to RESP.
- RESP:
  - rsp<owner>_valid held high, result and err stable, until rsp<owner>_ready.
  - On the handshake edge: rsp_valid drops, go to IDLE.
  - No new request is accepted in the handshake cycle.
- Timing:
  - Latency: request accepted at edge k, rsp_valid high after edge k+1.
  - Minimum of 3 cycles per operation.
- alu_* outputs hold their last values outside EXEC; no toggling in IDLE.
- rspN_result keeps its last value after the handshake.
- Requests that are not granted wait; the requester must hold its valid and operands stable.
- Opcodes pass through undecoded unless OPCHECK is enabled. Unknown codes yield whatever the ALU produces.
- Reset asserted mid-operation, in any state: immediately IDLE, all rsp_valid/ready low, the pending operation is discarded, last_grant=1.
- rst deasserted: first acceptance possible at the next rising edge.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - At acceptance, opcodes outside {0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT} skip the ALU.
  - Such a request goes IDLE -> RESP directly (1 cycle earlier), with rspN_result=0 and rspN_err=1.
  - Legal opcodes give rspN_err=0.
  - alu_* outputs are not updated for rejected opcodes.
- Undefined: all opcodes go to the ALU and rspN_err is tied 0.

Test Plan:
- Reset: rst=1 for 100ns -> all outputs 0, alu_operation=0000. Release, then req0 ADD data1=2 data2=1 -> req0_ready in the same cycle, rsp0_valid 2 cycles later, rsp0_result=3.
- Simultaneous request after reset: req0 AND 10,6 and req1 OR 10,5 -> req0 granted first, result 2; then req1, result 15. Next simultaneous pair -> req0 (last_grant=1 forces req0 first), then req1 again.
- Backpressure: req1 SUB 2,2 with rsp1_ready low for 5 cycles -> rsp1_valid held, result 0 stable; req0_ready stays low throughout even though req0_valid=1.
- Signed compare: req0 SLT data1=-10 (0xFFFFFFF6), data2=5 -> rsp0_result=1; alu_operation=0111 during EXEC only changes on acceptance.
- Reset mid-operation: assert rst during EXEC -> rsp_valid never rises, FSM in IDLE. A subsequent req1 ADD 7,8 -> rsp1_result=15.
- With ALU_ARB_OPCHECK_EN: req0 op=4'b1111 -> rsp0_valid 1 cycle after acceptance, rsp0_err=1, rsp0_result=0, alu_* unchanged. Without the macro: same stimulus -> 2-cycle latency, rsp0_err=0.
